// File: rtl/usb_rx_timing_ctrl.sv
// USB receive bit-timing sequencer: locks the sample phase to line edges, strobes the shift
// register once per bit, counts data bits per byte and watches for edge starvation.
module usb_rx_timing_ctrl #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int MAX_NO_EDGE  = 7
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable_timer,
  input  logic       d_edge,
  input  logic       stuff_bit,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [2:0] bit_index,
  output logic       bit_err
);

  localparam int PH_W = $clog2(CLKS_PER_BIT);
  localparam int EB_W = $clog2(MAX_NO_EDGE + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0] PH_SAMP = PH_W'(SAMPLE_POINT);
  localparam logic [EB_W-1:0] EB_MAX  = EB_W'(MAX_NO_EDGE);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, ERR} state_t;

  state_t          r_state;
  logic [PH_W-1:0] r_ph;
  logic [2:0]      r_bc;
  logic [EB_W-1:0] r_eb;
  logic            r_byte;
  logic            r_err;

  logic w_strobe;
  logic w_wrap;

  // The strobe decodes registered state only, so a same-cycle resync edge cannot cancel it.
  assign w_strobe = (r_state == RUN) && (r_ph == PH_SAMP);
  assign w_wrap   = (r_ph == PH_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_ph    <= '0;
      r_bc    <= '0;
      r_eb    <= '0;
      r_byte  <= 1'b0;
      r_err   <= 1'b0;
    end else if (!enable_timer) begin
      r_state <= IDLE;
      r_ph    <= '0;
      r_bc    <= '0;
      r_eb    <= '0;
      r_byte  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_byte <= 1'b0;
      case (r_state)
        IDLE: r_state <= SYNC;
        SYNC: begin
          r_ph <= '0;
          r_bc <= '0;
          r_eb <= '0;
          if (d_edge) r_state <= RUN;
        end
        RUN: begin
          r_ph <= (d_edge || w_wrap) ? '0 : r_ph + 1'b1;
          // Stuffed bits are strobed into the shifter but never counted as data.
          if (w_strobe && !stuff_bit) begin
            if (r_bc == 3'd7) begin
              r_bc   <= '0;
              r_byte <= 1'b1;
            end else begin
              r_bc <= r_bc + 1'b1;
            end
          end
          if (d_edge) begin
            r_eb <= '0;
          end else if (w_wrap) begin
            if (r_eb == EB_MAX) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_eb <= r_eb + 1'b1;
            end
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign shift_enable  = w_strobe;
  assign byte_received = r_byte;
  assign bit_index     = r_bc;
  assign bit_err       = r_err;

endmodule
